// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: HDLC transmit framer. Wraps a byte stream in opening and
// closing flags (0x7E), stuffs a 0 after every five consecutive 1s in the
// data/FCS region, and aborts the frame (0 + seven 1s) on request, on
// underrun, or when the byte limit is reached.
//
// Optional feature macro: HDLC_TX_FCS_EN -- when defined, a CRC-16/X.25 FCS
// is appended after the last data byte. Otherwise no CRC logic is built.
//
// Ports:
//   Clk, Rst           clock, asynchronous active-low reset
//   Tx_Start           one-cycle frame request (honoured only in IDLE)
//   Tx_Data/Valid/Last byte input, LSB first; transfer on Tx_Valid&&Tx_Ready
//   Tx_Ready           byte accepted this cycle
//   Tx_AbortFrame      abort the frame in progress
//   Tx                 registered serial line, idles at 1
//   Tx_ValidFrame      frame (or abort pattern) on the line
//   Tx_AbortedTrans    sticky: last frame ended by abort
//   Tx_Done            one-cycle pulse after a normal end flag
module hdlc_tx_framer #(
    parameter int MAX_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    input  logic       Tx_Last,
    output logic       Tx_Ready,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done
);
    localparam int         CW   = $clog2(MAX_BYTES + 1);
    localparam logic [7:0] FLAG = 8'b0111_1110;

    typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;

    // State/bitCnt/shReg describe the bit currently on Tx; the next-state
    // logic picks the following bit and Tx latches it.
    state_t        state, stateNext;
    logic [3:0]    bitCnt, bitNext;
    logic [15:0]   shReg, shNext;
    logic [2:0]    ones, onesNext;      // consecutive 1s up to and including Tx
    logic [CW-1:0] byteCnt, byteNext;
    logic          lastSeen, lastNext;  // Tx_Last byte already accepted
    logic          limitHit, limitNext; // MAX_BYTES accepted without Tx_Last
    logic          txNext, validNext, doneNext, abortedNext, load;
    logic          inFrame, unitEnd;
    logic [3:0]    lastIdx;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc, crcNext;

    // Reflected CRC-16 (poly 0x1021 -> 0x8408), one byte LSB first.
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
        return r;
    endfunction
`endif

    assign inFrame = (state == START_FLAG) || (state == DATA) ||
                     (state == FCS) || (state == END_FLAG);
    assign lastIdx = (state == FCS) ? 4'd15 : 4'd7;
    // A byte/FCS unit is finished once its last bit is on the line and no
    // stuff bit is still owed.
    assign unitEnd = (bitCnt == lastIdx) && (ones != 3'd5);

    assign Tx_Ready = ((state == START_FLAG) && (bitCnt == 4'd7)) ||
                      ((state == DATA) && unitEnd && !lastSeen && !limitHit);

    always_comb begin
        stateNext   = state;
        bitNext     = bitCnt;
        shNext      = shReg;
        onesNext    = ones;
        byteNext    = byteCnt;
        lastNext    = lastSeen;
        limitNext   = limitHit;
        txNext      = 1'b1;
        doneNext    = 1'b0;
        abortedNext = Tx_AbortedTrans;
        load        = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crcNext     = crc;
`endif
        if ((inFrame && Tx_AbortFrame) || (Tx_Ready && !Tx_Valid)) begin
            stateNext = ABORT;
            bitNext   = 4'd0;
            txNext    = 1'b0;
            onesNext  = 3'd0;
        end else begin
            case (state)
                IDLE: if (Tx_Start) begin
                    stateNext   = START_FLAG;
                    bitNext     = 4'd0;
                    txNext      = FLAG[0];
                    onesNext    = 3'd0;
                    byteNext    = '0;
                    lastNext    = 1'b0;
                    limitNext   = 1'b0;
                    abortedNext = 1'b0;
`ifdef HDLC_TX_FCS_EN
                    crcNext     = 16'hFFFF;
`endif
                end
                START_FLAG, END_FLAG: begin
                    if (bitCnt != 4'd7) begin
                        bitNext = bitCnt + 4'd1;
                        txNext  = FLAG[bitCnt[2:0] + 3'd1];
                    end else if (state == START_FLAG) begin
                        load = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
                DATA, FCS: begin
                    if (ones == 3'd5) begin
                        // stuff bit: shift register holds still
                        txNext   = 1'b0;
                        onesNext = 3'd0;
                    end else if (bitCnt != lastIdx) begin
                        shNext   = shReg >> 1;
                        bitNext  = bitCnt + 4'd1;
                        txNext   = shReg[1];
                        onesNext = shReg[1] ? ones + 3'd1 : 3'd0;
                    end else if (Tx_Ready) begin
                        load = 1'b1;
                    end else if ((state == DATA) && lastSeen) begin
`ifdef HDLC_TX_FCS_EN
                        stateNext = FCS;
                        shNext    = ~crc;
                        bitNext   = 4'd0;
                        txNext    = ~crc[0];
                        onesNext  = ~crc[0] ? ones + 3'd1 : 3'd0;
`else
                        stateNext = END_FLAG;
                        bitNext   = 4'd0;
                        txNext    = FLAG[0];
                        onesNext  = 3'd0;
`endif
                    end else if (state == DATA) begin
                        // byte limit reached without Tx_Last
                        stateNext = ABORT;
                        bitNext   = 4'd0;
                        txNext    = 1'b0;
                        onesNext  = 3'd0;
                    end else begin
                        stateNext = END_FLAG;
                        bitNext   = 4'd0;
                        txNext    = FLAG[0];
                        onesNext  = 3'd0;
                    end
                end
                ABORT: begin
                    if (bitCnt != 4'd7) begin
                        bitNext = bitCnt + 4'd1;
                    end else begin
                        stateNext   = IDLE;
                        abortedNext = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
            if (load) begin
                stateNext = DATA;
                shNext    = {8'h00, Tx_Data};
                bitNext   = 4'd0;
                txNext    = Tx_Data[0];
                onesNext  = Tx_Data[0] ? ones + 3'd1 : 3'd0;
                byteNext  = byteCnt + 1'b1;
                lastNext  = Tx_Last;
                limitNext = !Tx_Last && ((byteCnt + 1'b1) == CW'(MAX_BYTES));
`ifdef HDLC_TX_FCS_EN
                crcNext   = crcByte(crc, Tx_Data);
`endif
            end
        end
        validNext = (stateNext != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state           <= IDLE;
            bitCnt          <= '0;
            shReg           <= '0;
            ones            <= '0;
            byteCnt         <= '0;
            lastSeen        <= 1'b0;
            limitHit        <= 1'b0;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Done         <= 1'b0;
        end else begin
            state           <= stateNext;
            bitCnt          <= bitNext;
            shReg           <= shNext;
            ones            <= onesNext;
            byteCnt         <= byteNext;
            lastSeen        <= lastNext;
            limitHit        <= limitNext;
            Tx              <= txNext;
            Tx_ValidFrame   <= validNext;
            Tx_AbortedTrans <= abortedNext;
            Tx_Done         <= doneNext;
        end
    end

`ifdef HDLC_TX_FCS_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) crc <= 16'hFFFF;
        else      crc <= crcNext;
    end
`endif

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: reset state, idle line, normal frames
// compared bit-by-bit against a stuffing model, abort/underrun/priority/
// length-limit endings, mid-frame reset, and the "123456789" FCS vector.
module tb_hdlc_tx_framer;
    logic       Clk = 1'b0, Rst = 1'b0;
    logic       Tx_Start = 1'b0, Tx_Valid = 1'b0, Tx_Last = 1'b0, Tx_AbortFrame = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_Ready, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done;

    int         total = 0, bad = 0;
    int         doneCnt = 0, mOnes = 0;
    logic       bits[$];
    logic       expq[$];
    logic [7:0] frm[$];
    logic [7:0] flagPat = 8'h7E;

    always #5 Clk = ~Clk;

    hdlc_tx_framer #(.MAX_BYTES(128)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data),
        .Tx_Valid(Tx_Valid), .Tx_Last(Tx_Last), .Tx_Ready(Tx_Ready),
        .Tx_AbortFrame(Tx_AbortFrame), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
        .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done)
    );

    // line monitor, sampled away from the active edge
    always @(negedge Clk) begin
        if (Tx_ValidFrame) bits.push_back(Tx);
        if (Tx_Done) doneCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic pushStuffed(input logic b);
        expq.push_back(b);
        mOnes = b ? mOnes + 1 : 0;
        if (mOnes == 5) begin
            expq.push_back(1'b0);
            mOnes = 0;
        end
    endtask

    task automatic buildExp(input bit useFcs, input logic [15:0] fcs);
        expq.delete();
        mOnes = 0;
        for (int k = 0; k < 8; k++) expq.push_back(flagPat[k]);
        foreach (frm[i]) for (int k = 0; k < 8; k++) pushStuffed(frm[i][k]);
        if (useFcs) for (int k = 0; k < 16; k++) pushStuffed(fcs[k]);
        for (int k = 0; k < 8; k++) expq.push_back(flagPat[k]);
    endtask

    function automatic logic [15:0] fcsOf();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (frm[i]) for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ frm[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
        end
        return ~c;
    endfunction

    function automatic logic [7:0] last8();
        logic [7:0] v;
        v = 8'h00;
        if (bits.size() >= 8)
            for (int i = bits.size() - 8; i < bits.size(); i++) v = {v[6:0], bits[i]};
        return v;
    endfunction

    task automatic cmpStream(input string tag);
        int errs;
        errs = 0;
        chk({tag, "_len"}, bits.size(), expq.size());
        for (int i = 0; i < bits.size() && i < expq.size(); i++)
            if (bits[i] !== expq[i]) errs++;
        chk({tag, "_bits"}, errs, 0);
    endtask

    task automatic present(input int i, input bit withLast, input int dropIdx);
        Tx_Data  = (i < frm.size()) ? frm[i] : 8'h00;
        Tx_Valid = (i < frm.size()) && (i != dropIdx);
        Tx_Last  = withLast && (i == frm.size() - 1);
    endtask

    // Runs one frame from frm. abortIdx<0: no abort request. abortDly==0:
    // abort in the same cycle byte abortIdx transfers; >0: that many cycles
    // after it transferred. dropIdx: byte withheld (underrun).
    task automatic runFrame(input bit withLast, input int abortIdx, input int abortDly,
                            input int dropIdx);
        int  idx, since, cyc;
        bit  xfer;
        idx = 0; since = 0; cyc = 0;
        bits.delete();
        doneCnt = 0;
        @(negedge Clk);
        Tx_Start = 1'b1;
        present(0, withLast, dropIdx);
        @(negedge Clk);
        Tx_Start = 1'b0;
        while (cyc < 3000) begin
            if (!Tx_ValidFrame) break;
            Tx_AbortFrame = 1'b0;
            if (abortIdx >= 0) begin
                if (abortDly == 0 && idx == abortIdx && Tx_Ready && Tx_Valid) Tx_AbortFrame = 1'b1;
                if (abortDly > 0 && idx == abortIdx + 1 && since == abortDly) Tx_AbortFrame = 1'b1;
            end
            xfer = Tx_Ready && Tx_Valid;
            @(posedge Clk);
            #1;
            cyc++;
            since++;
            Tx_AbortFrame = 1'b0;
            if (xfer) begin
                idx++;
                since = 0;
                present(idx, withLast, dropIdx);
            end
            @(negedge Clk);
        end
        if (cyc >= 3000) chk("frame_timeout", 1, 0);
        Tx_Valid = 1'b0;
        Tx_Last  = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        logic [31:0] v;
        int          errs;
        `ifdef HDLC_TX_FCS_EN
        bit fcsOn = 1'b1;
        `else
        bit fcsOn = 1'b0;
        `endif

        // reset state
        repeat (3) @(negedge Clk);
        chk("rst_tx", Tx, 1);
        chk("rst_valid", Tx_ValidFrame, 0);
        chk("rst_ready", Tx_Ready, 0);
        chk("rst_aborted", Tx_AbortedTrans, 0);
        chk("rst_done", Tx_Done, 0);
        Rst = 1'b1;

        // idle line
        errs = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0) errs++;
        end
        chk("idle", errs, 0);

        // abort during 3rd byte: 8 flag + 16 data + 4 bits of byte 2 + 8 abort
        frm = '{8'h11, 8'h22, 8'h33, 8'h44};
        runFrame(1'b1, 2, 3, -1);
        chk("abt3_len", bits.size(), 36);
        chk("abt3_pat", last8(), 8'h7F);
        chk("abt3_sticky", Tx_AbortedTrans, 1);
        chk("abt3_valid", Tx_ValidFrame, 0);
        chk("abt3_done", doneCnt, 0);

        // single 0xFF: stuffed after five 1s; new start clears the sticky abort
        frm = '{8'hFF};
        runFrame(1'b1, -1, 0, -1);
        buildExp(fcsOn, fcsOf());
        cmpStream("ff");
        `ifndef HDLC_TX_FCS_EN
        v = 0;
        foreach (bits[i]) v = {v[30:0], bits[i]};
        chk("ff_pattern", v, 32'b0111111011111011101111110);
        `endif
        chk("ff_done", doneCnt, 1);
        chk("ff_aborted_clr", Tx_AbortedTrans, 0);

        // stuffing across byte boundaries and right before the end flag
        frm = '{8'h7E, 8'h3E, 8'hF8};
        runFrame(1'b1, -1, 0, -1);
        buildExp(fcsOn, fcsOf());
        cmpStream("multi");
        chk("multi_done", doneCnt, 1);

        // underrun on the second byte
        frm = '{8'h55, 8'h66};
        runFrame(1'b1, -1, 0, 1);
        chk("undr_len", bits.size(), 24);
        chk("undr_pat", last8(), 8'h7F);
        chk("undr_sticky", Tx_AbortedTrans, 1);

        // abort coinciding with the Tx_Last transfer wins
        frm = '{8'h0F, 8'hA5};
        runFrame(1'b1, 1, 0, -1);
        chk("prio_len", bits.size(), 24);
        chk("prio_pat", last8(), 8'h7F);
        chk("prio_done", doneCnt, 0);

        // length limit: 128 zero bytes, no Tx_Last
        frm.delete();
        repeat (128) frm.push_back(8'h00);
        runFrame(1'b0, -1, 0, -1);
        chk("lim_len", bits.size(), 8 + 128 * 8 + 8);
        chk("lim_pat", last8(), 8'h7F);
        chk("lim_sticky", Tx_AbortedTrans, 1);
        chk("lim_done", doneCnt, 0);

        // "123456789": FCS 0x906E goes out as 0x6E then 0x90
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        runFrame(1'b1, -1, 0, -1);
        buildExp(fcsOn, 16'h906E);
        cmpStream("chk9");
        chk("chk9_done", doneCnt, 1);

        // reset mid-frame truncates at once
        frm = '{8'hAA, 8'hAA};
        @(negedge Clk);
        Tx_Start = 1'b1;
        present(0, 1'b1, -1);
        @(negedge Clk);
        Tx_Start = 1'b0;
        repeat (5) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("mrst_tx", Tx, 1);
        chk("mrst_valid", Tx_ValidFrame, 0);
        chk("mrst_ready", Tx_Ready, 0);
        Tx_Valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("mrst_idle", Tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
